// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
// uart_tx_fifo
// UART transmitter (8N1, LSB first) fed by a small byte FIFO so that several
// queued bytes leave back-to-back with no idle gap between frames.
//
// Parameters:
//   CLKS_PER_BIT  osc_clk cycles per serial bit (>= 2, <= 65535)
//   FIFO_AW       FIFO address width, depth = 2**FIFO_AW
//
// Ports:
//   osc_clk       system clock, rising edge
//   i_Reset       synchronous active-high reset
//   i_Tx_DV       write strobe, one byte per cycle
//   i_Tx_Byte     byte to queue
//   o_Tx_Ready    FIFO not full
//   o_Tx_Serial   registered serial line, idle high
//   o_Tx_Active   high from start bit through stop bit
//   o_Tx_Done     one-cycle pulse on the last cycle of each stop bit
//   o_Overflow    one-cycle pulse after a write was dropped on a full FIFO
//   o_Fifo_Count  bytes waiting in the FIFO (excludes the byte being sent)
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 1155,
  parameter int FIFO_AW      = 4
) (
  input  logic               osc_clk,
  input  logic               i_Reset,
  input  logic               i_Tx_DV,
  input  logic [7:0]         i_Tx_Byte,
  output logic               o_Tx_Ready,
  output logic               o_Tx_Serial,
  output logic               o_Tx_Active,
  output logic               o_Tx_Done,
  output logic               o_Overflow,
  output logic [FIFO_AW:0]   o_Fifo_Count
);

  localparam int                DEPTH     = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0]  DEPTH_CNT = (FIFO_AW + 1)'(DEPTH);
  localparam logic [15:0]       LAST_CNT  = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    STOP_BIT
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [15:0]         clk_cnt;
  logic [15:0]         clk_cnt_next;
  logic [2:0]          bit_idx;
  logic [2:0]          bit_idx_next;
  logic [2:0]          idx_inc;
  logic [7:0]          shift_reg;
  logic [7:0]          shift_next;
  logic                serial_next;
  logic                active_next;

  logic [7:0]          fifo_mem [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr;
  logic [FIFO_AW-1:0]  rd_ptr;
  logic [FIFO_AW:0]    count;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic                bit_end;

  // Fullness is judged on the count before any pop in the same cycle, so a
  // write that coincides with a pop on a full FIFO is still dropped.
  assign fifo_full    = (count == DEPTH_CNT);
  assign fifo_empty   = (count == '0);
  assign push         = i_Tx_DV && !fifo_full;
  assign bit_end      = (clk_cnt == LAST_CNT);
  assign idx_inc      = bit_idx + 3'd1;

  assign o_Tx_Ready   = !fifo_full;
  assign o_Fifo_Count = count;
  assign o_Tx_Done    = (state == STOP_BIT) && bit_end;

  // Next-state logic. The serial line value for the coming cycle is decided
  // here and registered, so o_Tx_Serial changes exactly on the bit boundary.
  always_comb begin
    state_next   = state;
    clk_cnt_next = clk_cnt + 16'd1;
    bit_idx_next = bit_idx;
    shift_next   = shift_reg;
    serial_next  = o_Tx_Serial;
    active_next  = o_Tx_Active;
    pop          = 1'b0;

    case (state)
      IDLE: begin
        clk_cnt_next = '0;
        serial_next  = 1'b1;
        active_next  = 1'b0;
        if (!fifo_empty) begin
          pop         = 1'b1;
          shift_next  = fifo_mem[rd_ptr];
          state_next  = START_BIT;
          serial_next = 1'b0;
          active_next = 1'b1;
        end
      end

      START_BIT: begin
        if (bit_end) begin
          clk_cnt_next = '0;
          bit_idx_next = 3'd0;
          state_next   = DATA_BITS;
          serial_next  = shift_reg[0];
        end
      end

      DATA_BITS: begin
        if (bit_end) begin
          clk_cnt_next = '0;
          if (bit_idx == 3'd7) begin
            state_next  = STOP_BIT;
            serial_next = 1'b1;
          end else begin
            bit_idx_next = idx_inc;
            serial_next  = shift_reg[idx_inc];
          end
        end
      end

      STOP_BIT: begin
        if (bit_end) begin
          clk_cnt_next = '0;
          // Chain straight into the next start bit when more data waits.
          if (!fifo_empty) begin
            pop         = 1'b1;
            shift_next  = fifo_mem[rd_ptr];
            state_next  = START_BIT;
            serial_next = 1'b0;
          end else begin
            state_next  = IDLE;
            serial_next = 1'b1;
            active_next = 1'b0;
          end
        end
      end

      default: begin
        state_next   = IDLE;
        clk_cnt_next = '0;
        serial_next  = 1'b1;
        active_next  = 1'b0;
      end
    endcase
  end

  // Transmitter state register; reset aborts any frame in progress.
  always_ff @(posedge osc_clk) begin
    if (i_Reset) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      o_Tx_Serial <= 1'b1;
      o_Tx_Active <= 1'b0;
    end else begin
      state       <= state_next;
      clk_cnt     <= clk_cnt_next;
      bit_idx     <= bit_idx_next;
      shift_reg   <= shift_next;
      o_Tx_Serial <= serial_next;
      o_Tx_Active <= active_next;
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge osc_clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= i_Tx_Byte;
    end
  end

  // FIFO pointers, occupancy and overflow flag.
  always_ff @(posedge osc_clk) begin
    if (i_Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_Overflow <= 1'b0;
    end else begin
      o_Overflow <= i_Tx_DV && fifo_full;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
